// File: rtl/pre_if_stage.sv
// rtl/pre_if_stage.sv - fetch-request stage feeding if_stage over an SRAM-like split-handshake bus
//
// Optional feature macro: PREIF_ADEF_CHECK_EN (fetch address alignment exception)
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   br_bus[32:0]          {br_taken, br_target}; single-cycle redirect from ID
//   if_allow_in           if_stage accepts this cycle
//   to_if_valid           to_if_bus holds a fetched instruction
//   to_if_bus[64:0]       {excp_adef, pc, inst}
//   inst_sram_*           instruction bus (req/addr_ok request phase, data_ok response phase)
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [32:0] br_bus,
    input  logic        if_allow_in,
    output logic        to_if_valid,
    output logic [64:0] to_if_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc;
    logic        discard;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;
    logic        buf_excp;
    logic        adef_hold;   // exception already delivered; park until a redirect

    logic        br_taken;
    logic [31:0] br_target;
    logic        adef;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

`ifdef PREIF_ADEF_CHECK_EN
    assign adef = (fetch_pc[1:0] != 2'b00);
`else
    assign adef = 1'b0;
`endif

    // State register resets to REQ, so the request is gated by resetn to stay low during reset.
    assign inst_sram_req   = resetn && (state == REQ) && !adef;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    // A redirect in the same cycle kills the hand-off combinationally.
    assign to_if_valid = (state == HOLD) && !br_taken;
    assign to_if_bus   = {buf_excp, buf_pc, buf_inst};

    always_comb begin
        state_next = state;
        case (state)
            REQ: begin
                if (adef) begin
                    if (!adef_hold && !br_taken && !redir_valid) state_next = HOLD;
                end else if (inst_sram_addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (inst_sram_data_ok) state_next = (discard || br_taken) ? REQ : HOLD;
            end
            HOLD: begin
                if (br_taken || if_allow_in) state_next = REQ;
            end
            default: state_next = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            discard     <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= 32'h0;
            buf_pc      <= 32'h0;
            buf_inst    <= 32'h0;
            buf_excp    <= 1'b0;
            adef_hold   <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (adef) begin
                        // No bus request is made for a misaligned PC; a redirect replaces it directly.
                        if (br_taken) begin
                            fetch_pc    <= br_target;
                            redir_valid <= 1'b0;
                            adef_hold   <= 1'b0;
                        end else if (redir_valid) begin
                            fetch_pc    <= redir_pc;
                            redir_valid <= 1'b0;
                            adef_hold   <= 1'b0;
                        end else if (!adef_hold) begin
                            buf_excp <= 1'b1;
                            buf_pc   <= fetch_pc;
                            buf_inst <= 32'h0;
                        end
                    end else if (inst_sram_addr_ok) begin
                        // The accepted request is wrong-path if any redirect arrived while it was held.
                        if (br_taken) begin
                            discard     <= 1'b1;
                            fetch_pc    <= br_target;
                            redir_valid <= 1'b0;
                        end else if (redir_valid) begin
                            discard     <= 1'b1;
                            fetch_pc    <= redir_pc;
                            redir_valid <= 1'b0;
                        end
                    end else if (br_taken) begin
                        // Address must stay stable until addr_ok, so the redirect is parked.
                        redir_valid <= 1'b1;
                        redir_pc    <= br_target;
                    end
                end
                WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (discard || br_taken) begin
                            discard <= 1'b0;
                            if (br_taken) fetch_pc <= br_target;
                        end else begin
                            buf_pc   <= fetch_pc;
                            buf_inst <= inst_sram_rdata;
                            buf_excp <= 1'b0;
                        end
                    end else if (br_taken) begin
                        discard  <= 1'b1;
                        fetch_pc <= br_target;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        fetch_pc  <= br_target;
                        adef_hold <= 1'b0;
                    end else if (if_allow_in) begin
                        fetch_pc  <= buf_pc + 32'd4;
                        adef_hold <= buf_excp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// tb/tb_pre_if_stage.sv - scoreboard testbench for pre_if_stage
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic [32:0] br_bus;
    logic        if_allow_in;
    logic        to_if_valid;
    logic [64:0] to_if_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [64:0] exp_bus_q[$];
    logic [31:0] exp_addr_q[$];

    pre_if_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .br_bus            (br_bus),
        .if_allow_in       (if_allow_in),
        .to_if_valid       (to_if_valid),
        .to_if_bus         (to_if_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted request and every transfer to if_stage is matched against the queues.
    always @(negedge clk) begin
        if (resetn === 1'b1 && inst_sram_req && inst_sram_addr_ok) begin
            if (exp_addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_req: got addr %h expected none", inst_sram_addr);
            end else begin
                check("req_addr", {33'h0, inst_sram_addr}, {33'h0, exp_addr_q.pop_front()});
            end
        end
        if (resetn === 1'b1 && to_if_valid && if_allow_in) begin
            if (exp_bus_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_xfer: got bus %h expected none", to_if_bus);
            end else begin
                check("xfer_bus", to_if_bus, exp_bus_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept the held request after a_wait idle cycles, return data d_wait cycles after WAIT entry.
    task automatic txn(input int a_wait, input int d_wait, input logic [31:0] data);
        repeat (a_wait) tick();
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        repeat (d_wait) tick();
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = data;
        tick();
        inst_sram_data_ok = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] held;
        resetn = 1'b0;
        br_bus = 33'h0;
        if_allow_in = 1'b1;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = 32'h0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_req",   {64'h0, inst_sram_req}, 65'h0);
        check("rst_valid", {64'h0, to_if_valid}, 65'h0);
        check("rst_bus",   to_if_bus, 65'h0);
        check("consts", {33'h0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata[24:0]},
              {33'h0, 1'b0, 2'b10, 4'b0000, 25'h0});
        @(posedge clk); #1;
        resetn = 1'b1;

        // Basic fetch after reset.
        #1 check("req_after_rst", {64'h0, inst_sram_req}, 65'h1);
        exp_addr_q.push_back(32'h1c000000);
        exp_bus_q.push_back({1'b0, 32'h1c000000, 32'h02800421});
        txn(1, 0, 32'h02800421);
        tick();
        @(negedge clk);
        check("next_req", {32'h0, inst_sram_req, inst_sram_addr}, {32'h0, 1'b1, 32'h1c000004});

        // Stall in HOLD for 5 cycles.
        if_allow_in = 1'b0;
        exp_addr_q.push_back(32'h1c000004);
        txn(0, 1, 32'h11111111);
        held = {1'b0, 32'h1c000004, 32'h11111111};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {64'h0, to_if_valid}, 65'h1);
            check("stall_bus", to_if_bus, held);
            check("stall_req", {64'h0, inst_sram_req}, 65'h0);
            tick();
        end
        exp_bus_q.push_back(held);
        if_allow_in = 1'b1;
        tick();
        @(negedge clk);
        check("after_stall", {32'h0, inst_sram_req, inst_sram_addr}, {32'h0, 1'b1, 32'h1c000008});

        // Redirect while waiting for data.
        exp_addr_q.push_back(32'h1c000008);
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        br_bus = {1'b1, 32'h1c000100};
        tick();
        br_bus = 33'h0;
        tick();
        tick();
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'hdeadbeef;
        tick();
        inst_sram_data_ok = 1'b0;
        @(negedge clk);
        check("wait_redir", {32'h0, inst_sram_req, inst_sram_addr}, {32'h0, 1'b1, 32'h1c000100});
        exp_addr_q.push_back(32'h1c000100);
        exp_bus_q.push_back({1'b0, 32'h1c000100, 32'h22222222});
        txn(0, 0, 32'h22222222);
        tick();

        // Redirect while request is held without addr_ok.
        for (int i = 0; i < 4; i++) begin
            br_bus = (i == 2) ? {1'b1, 32'h1c000200} : 33'h0;
            @(negedge clk);
            check("held_addr", {32'h0, inst_sram_req, inst_sram_addr}, {32'h0, 1'b1, 32'h1c000104});
            tick();
        end
        br_bus = 33'h0;
        exp_addr_q.push_back(32'h1c000104);
        txn(0, 0, 32'hbadbad00);
        @(negedge clk);
        check("req_redir", {32'h0, inst_sram_req, inst_sram_addr}, {32'h0, 1'b1, 32'h1c000200});
        exp_addr_q.push_back(32'h1c000200);
        exp_bus_q.push_back({1'b0, 32'h1c000200, 32'h33333333});
        txn(0, 0, 32'h33333333);
        tick();

        // Branch and allow_in in the same HOLD cycle.
        exp_addr_q.push_back(32'h1c000204);
        txn(0, 0, 32'h44444444);
        br_bus = {1'b1, 32'h1c000300};
        @(negedge clk);
        check("hold_br_valid", {64'h0, to_if_valid}, 65'h0);
        tick();
        br_bus = 33'h0;
        @(negedge clk);
        check("hold_br_req", {32'h0, inst_sram_req, inst_sram_addr}, {32'h0, 1'b1, 32'h1c000300});

        // Reset in WAIT.
        exp_addr_q.push_back(32'h1c000300);
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        check("async_rst", {to_if_valid, inst_sram_req, to_if_bus[62:0]}, 65'h0);
        tick();
        resetn = 1'b1;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'hcafef00d;
        tick();
        inst_sram_data_ok = 1'b0;
        @(negedge clk);
        check("post_rst_req", {31'h0, to_if_valid, inst_sram_req, inst_sram_addr},
              {31'h0, 1'b0, 1'b1, 32'h1c000000});
        exp_addr_q.push_back(32'h1c000000);
        exp_bus_q.push_back({1'b0, 32'h1c000000, 32'h55555555});
        txn(0, 0, 32'h55555555);
        repeat (2) tick();

        check("addr_q_empty", exp_addr_q.size(), 0);
        check("bus_q_empty",  exp_bus_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
